// File: rtl/stopwatch_counter.sv
// Purpose: stopwatch time base and packed-BCD counter (00.00..99.99 s) with start/stop/reset run control.
// Latency: button level to state change is 3 edges (2-flop sync + edge flop); x updates on the tick edge itself.
// Backpressure: none; free-running, x holds in PAUSE/IDLE and is stable for a full tick period.
//
// Ports:
//   clk      system clock, all logic on rising edge
//   clr      synchronous active-high reset, clears every flop
//   btn_ss   start/stop button level (asynchronous, pre-debounced)
//   btn_rst  stopwatch-reset button level (asynchronous, pre-debounced)
//   x        packed BCD time {tens s, s, tens cs, cs}, registered
//   running  high while in RUN, registered
//   ovf      sticky wrap flag (99.99 -> 00.00), registered
module stopwatch_counter #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        btn_ss,
    input  logic        btn_rst,
    output logic [15:0] x,
    output logic        running,
    output logic        ovf
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;

    // [0] and [1] form the synchronizer, [2] is the edge-detect delay flop.
    logic [2:0] ss_sync;
    logic [2:0] rst_sync;

    logic ss_p;
    logic rst_p;
    logic tick;

    logic [15:0] x_inc;
    logic        x_wrap;

    assign ss_p  = ss_sync[1]  & ~ss_sync[2];
    assign rst_p = rst_sync[1] & ~rst_sync[2];
    assign tick  = (state == RUN) && (presc == PMAX);

    // Ripple BCD increment; the final carry out of the tens-of-seconds digit
    // is the 99.99 -> 00.00 wrap.
    always_comb begin
        logic       c;
        logic [3:0] d;
        x_inc  = x;
        x_wrap = 1'b0;
        c      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = x[i*4 +: 4];
            if (c) begin
                if (d == 4'd9) begin
                    x_inc[i*4 +: 4] = 4'd0;
                end else begin
                    x_inc[i*4 +: 4] = d + 4'd1;
                    c = 1'b0;
                end
            end
        end
        x_wrap = c;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ss_sync  <= '0;
            rst_sync <= '0;
            state    <= IDLE;
            running  <= 1'b0;
            presc    <= '0;
            x        <= '0;
            ovf      <= 1'b0;
        end else begin
            ss_sync  <= {ss_sync[1:0],  btn_ss};
            rst_sync <= {rst_sync[1:0], btn_rst};

            if (rst_p) begin
                // Reset wins over a simultaneous start/stop and over a tick.
                state   <= IDLE;
                running <= 1'b0;
                presc   <= '0;
                x       <= '0;
                ovf     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        presc <= '0;
                        if (ss_p) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        // The tick increment still lands if a pause arrives on the same edge.
                        if (tick) begin
                            presc <= '0;
                            x     <= x_inc;
                            if (x_wrap) begin
                                ovf <= 1'b1;
                            end
                        end else begin
                            presc <= presc + PW'(1);
                        end
                        if (ss_p) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        // Prescaler holds so a resume finishes the partial interval.
                        if (ss_p) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                        presc   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Purpose: directed self-checking bench for stopwatch_counter with TICK_DIV = 4.
// Latency: checks are taken 1 ns after each rising edge; inputs change at the same point.
// Backpressure: not applicable.
module tb_stopwatch_counter;

    logic        clk;
    logic        clr;
    logic        btn_ss;
    logic        btn_rst;
    logic [15:0] x;
    logic        running;
    logic        ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    stopwatch_counter #(.TICK_DIV(4)) dut (
        .clk     (clk),
        .clr     (clr),
        .btn_ss  (btn_ss),
        .btn_rst (btn_rst),
        .x       (x),
        .running (running),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] ex, input logic er, input logic eo);
        chk({tag, ".x"},       x,                {ex});
        chk({tag, ".running"}, {15'd0, running}, {15'd0, er});
        chk({tag, ".ovf"},     {15'd0, ovf},     {15'd0, eo});
    endtask

    initial begin
        clr     = 1'b1;
        btn_ss  = 1'b0;
        btn_rst = 1'b0;

        // Reset and idle.
        step(3);
        chk_all("reset", 16'h0000, 1'b0, 1'b0);
        clr = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            chk_all("idle", 16'h0000, 1'b0, 1'b0);
        end

        // Start: button sampled at P1, RUN entered at P3, ticks at P3+4n.
        btn_ss = 1'b1;
        step(2);  chk("start_lat2", {15'd0, running}, 16'd0);
        step(1);  chk("start_lat3", {15'd0, running}, 16'd1);
        step(7);  btn_ss = 1'b0;
        chk_all("held_one_pulse", 16'h0001, 1'b1, 1'b0);
        step(40); chk("cnt_11", x, 16'h0011);
        step(1);  chk("cnt_12", x, 16'h0012);
        step(351); chk("cnt_99", x, 16'h0099);

        // Pause: press lands so the prescaler freezes at 2.
        btn_ss = 1'b1;
        step(1);  chk("carry_100", x, 16'h0100);
        step(1);  btn_ss = 1'b0;
        step(1);  chk_all("paused", 16'h0100, 1'b0, 1'b0);
        step(50); chk_all("pause_hold", 16'h0100, 1'b0, 1'b0);

        // Resume: 2 remaining prescaler cycles after RUN re-entry.
        btn_ss = 1'b1;
        step(2);  btn_ss = 1'b0;
        chk("resume_lat2", {15'd0, running}, 16'd0);
        step(1);  chk("resume_lat3", {15'd0, running}, 16'd1);
        step(1);  chk("resume_partial", x, 16'h0100);
        step(1);  chk("resume_tick", x, 16'h0101);

        // Rollover.
        step(39591); chk_all("pre_9998", 16'h9998, 1'b1, 1'b0);
        step(1);     chk_all("at_9999",  16'h9999, 1'b1, 1'b0);
        step(3);     chk("hold_9999", x, 16'h9999);
        step(1);     chk_all("wrap", 16'h0000, 1'b1, 1'b1);

        // clr mid-operation with a button held: no pulse while clr is high.
        step(16968); chk_all("at_4242", 16'h4242, 1'b1, 1'b1);
        clr    = 1'b1;
        btn_ss = 1'b1;
        step(1);  chk_all("clr_edge", 16'h0000, 1'b0, 1'b0);
        step(2);  chk_all("clr_held", 16'h0000, 1'b0, 1'b0);
        clr = 1'b0;
        step(2);  chk("post_clr_lat2", {15'd0, running}, 16'd0);
        step(1);  chk("post_clr_pulse", {15'd0, running}, 16'd1);
        btn_ss = 1'b0;

        // Reset priority over start/stop at x = 0537.
        step(2146); chk("cnt_536", x, 16'h0536);
        btn_ss  = 1'b1;
        btn_rst = 1'b1;
        step(1);  chk_all("prio_e1", 16'h0536, 1'b1, 1'b0);
        step(1);  chk_all("prio_e2", 16'h0537, 1'b1, 1'b0);
        step(1);  chk_all("prio_rst", 16'h0000, 1'b0, 1'b0);
        btn_ss  = 1'b0;
        btn_rst = 1'b0;
        step(5);  chk_all("idle_after_rst", 16'h0000, 1'b0, 1'b0);

        // A later start must come from IDLE with a cleared prescaler.
        btn_ss = 1'b1;
        step(3);  chk("restart", {15'd0, running}, 16'd1);
        btn_ss = 1'b0;
        step(3);  chk("restart_pre", x, 16'h0000);
        step(1);  chk("restart_tick", x, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
